// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready back-pressure, flush-to-bubble and occupancy.
// Optional PIPE_STAT_EN macro adds saturating stall/flush cycle counters as extra output ports.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 13,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy
`ifdef PIPE_STAT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH:0]    adv;
    logic              accept;
    logic [2:0]        occ_q;
    logic [2:0]        occ_d;

    // A stage may move if it is empty or anything downstream of it can move.
    always_comb begin
        logic chain;
        chain      = out_ready;
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = chain | ~valid_q[i];
            adv[i] = chain;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_d[i] = ctrl_q[i];
            data_d[i] = data_q[i];
        end
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = '0;
            end
        end else begin
            if (adv[0]) begin
                valid_d[0] = accept;
                ctrl_d[0]  = accept ? in_ctrl : '0;
                if (accept) begin
                    data_d[0] = in_data;
                end
            end
            // Emptied stages keep stale data but always carry zero control.
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid_d[i] = valid_q[i-1];
                    ctrl_d[i]  = valid_q[i-1] ? ctrl_q[i-1] : '0;
                    if (valid_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + 3'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= ctrl_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef PIPE_STAT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DEPTH=3): queue-based reference model plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int DEPTH = 3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [12:0]  in_ctrl;
    logic [159:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [12:0]  out_ctrl;
    logic [159:0] out_data;
    logic [2:0]   occupancy;
`ifdef PIPE_STAT_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    pipe_stage_reg #(.DATA_W(160), .CTRL_W(13), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [12:0] c, input logic [159:0] d,
                                 input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: in-flight bundles oldest first, each tagged with its stage position.
    typedef struct {
        logic [12:0]  ctrl;
        logic [159:0] data;
        int           pos;
    } entry_t;

    entry_t mq[$];
    bit     model_on = 0;
    int     m_stall = 0;
    int     m_flush = 0;

    initial begin
        int     n;
        bit     acc;
        bit     head_out;
        entry_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_stall  = 0;
                m_flush  = 0;
                model_on = 1;
            end else if (model_on) begin
                n        = mq.size();
                head_out = (n > 0) && (mq[0].pos == DEPTH - 1);
                acc      = in_valid && !flush && (n < DEPTH || out_ready);
                if (head_out && !out_ready) m_stall++;
                if (flush) m_flush++;
                // A bundle moves if there is a gap ahead of it or the output drains.
                for (int k = 0; k < n; k++) begin
                    if (out_ready || k < DEPTH - 1 - mq[k].pos) mq[k].pos++;
                end
                if (n > 0 && mq[0].pos == DEPTH) void'(mq.pop_front());
                if (flush) mq.delete();
                if (acc) begin
                    e.ctrl = in_ctrl;
                    e.data = in_data;
                    e.pos  = 0;
                    mq.push_back(e);
                end
            end
        end
    end

    int seen77 = 0;

    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (model_on) begin
                exp_v = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
                checkOutput("m_out_valid", out_valid, exp_v);
                checkOutput("m_out_ctrl", out_ctrl, exp_v ? mq[0].ctrl : 13'h0);
                if (exp_v) checkOutput("m_out_data", out_data, mq[0].data);
                checkOutput("m_occupancy", occupancy, mq.size());
                checkOutput("m_in_ready", in_ready, !flush && (mq.size() < DEPTH || out_ready));
`ifdef PIPE_STAT_EN
                checkOutput("m_stall_cnt", stall_cnt, m_stall);
                checkOutput("m_flush_cnt", flush_cnt, m_flush);
`endif
                if (!rst && out_valid && out_ready && out_data == 160'h77) seen77++;
            end
        end
    end

    initial begin
        // Reset state
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_ctrl", out_ctrl, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        // Streaming at full rate
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 13'(k), 160'(k), 1, 0, 0);
            if (k == 3) begin
                checkOutput("stream_first_data", out_data, 1);
                checkOutput("stream_first_valid", out_valid, 1);
                checkOutput("stream_occ3", occupancy, 3);
            end
        end
        checkOutput("stream_data3", out_data, 3);
        checkOutput("stream_steady_occ", occupancy, 3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("drain_data4", out_data, 4);
        checkOutput("drain_occ2", occupancy, 2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("drain_data5", out_data, 5);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("drain_empty_valid", out_valid, 0);
        checkOutput("drain_empty_ctrl", out_ctrl, 0);

        // Back-pressure: bubbles collapse, then the head holds still
        applyStimulus(1, 1, 160'hAA, 0, 0, 0);
        applyStimulus(1, 2, 160'hBB, 0, 0, 0);
        applyStimulus(1, 3, 160'hCC, 0, 0, 0);
        checkOutput("stall_full_occ", occupancy, 3);
        checkOutput("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 4, 160'hDD, 0, 0, 0);
            checkOutput("stall_hold_data", out_data, 160'hAA);
            checkOutput("stall_hold_ctrl", out_ctrl, 1);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("release_bb", out_data, 160'hBB);
        checkOutput("release_occ2", occupancy, 2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("release_cc", out_data, 160'hCC);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("release_empty", out_valid, 0);

        // Flush with three bundles in flight
        applyStimulus(1, 13'h1FFF, 160'h11, 0, 0, 0);
        applyStimulus(1, 13'h1FFF, 160'h22, 0, 0, 0);
        applyStimulus(1, 13'h1FFF, 160'h33, 0, 0, 0);
        checkOutput("preflush_ctrl", out_ctrl, 13'h1FFF);
        applyStimulus(1, 13'h1FFF, 160'hEE, 0, 1, 0);
        checkOutput("flush_occ", occupancy, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_out_ctrl", out_ctrl, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("flush_no_accept", out_valid, 0);
        checkOutput("flush_no_accept_occ", occupancy, 0);

        // Flush on the same edge as a delivery
        applyStimulus(1, 7, 160'h77, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("f2_head_valid", out_valid, 1);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("f2_after_valid", out_valid, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("f2_delivered_once", seen77, 1);
        checkOutput("f2_no_dup", out_valid, 0);

        // Reset in the middle of a stalled stream
        applyStimulus(1, 5, 160'h61, 0, 0, 0);
        applyStimulus(1, 6, 160'h62, 0, 0, 0);
        checkOutput("mrst_pre_occ", occupancy, 2);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("mrst_valid", out_valid, 0);
        checkOutput("mrst_ctrl", out_ctrl, 0);
        checkOutput("mrst_data", out_data, 0);
        checkOutput("mrst_occ", occupancy, 0);
        checkOutput("mrst_in_ready", in_ready, 1);
        applyStimulus(1, 7, 160'h55, 1, 0, 0);
        checkOutput("mrst_accept_occ", occupancy, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("mrst_deliver_data", out_data, 160'h55);
        checkOutput("mrst_deliver_valid", out_valid, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);

`ifdef PIPE_STAT_EN
        // Counters: five stalled cycles, then two flush cycles
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(1, 9, 160'h99, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("stat_stall5", stall_cnt, 5);
        checkOutput("stat_flush2", flush_cnt, 2);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("stat_rst_stall", stall_cnt, 0);
        checkOutput("stat_rst_flush", flush_cnt, 0);
`endif

        applyStimulus(0, 0, 0, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
